cic_comp_interp: RTL and testbench

//   Transmit-path (DAC side) CIC compensation interpolator, x2 upsampling. Takes 35-bit

---
 rtl/cic_comp_interp_pkg.sv | 27 ++
 rtl/cic_comp_interp_mac.sv | 69 ++++++
 rtl/cic_comp_interp.sv | 92 +++++++++
 tb/tb_cic_comp_interp.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_comp_interp_pkg.sv
// Shared constants and types for the x2 CIC compensation interpolator.
package cic_comp_pkg;

    // Coefficient width; the taps are signed Q30
    localparam int unsigned COMP_CW = 31;

    // Half of the symmetric 15-tap compensation FIR (c0..c7, c7 is the centre tap)
    localparam logic signed [COMP_CW-1:0] COMP_C0 = -31'sd6421026;
    localparam logic signed [COMP_CW-1:0] COMP_C1 = -31'sd1088314;
    localparam logic signed [COMP_CW-1:0] COMP_C2 =  31'sd34811522;
    localparam logic signed [COMP_CW-1:0] COMP_C3 =  31'sd8641811;
    localparam logic signed [COMP_CW-1:0] COMP_C4 = -31'sd116533699;
    localparam logic signed [COMP_CW-1:0] COMP_C5 = -31'sd53216433;
    localparam logic signed [COMP_CW-1:0] COMP_C6 =  31'sd356375486;
    localparam logic signed [COMP_CW-1:0] COMP_C7 =  31'sd628155438;

    // Q30 scaling combined with the x2 gain that restores zero-stuffing loss
    localparam int unsigned SHIFT = 29;

    // Phase sequencer: idle, even branch, odd branch
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PH0  = 2'd1,
        ST_PH1  = 2'd2
    } comp_state_e;

endpackage

// File: rtl/cic_comp_interp_mac.sv
// Combinational polyphase MAC shared by the even and odd phases.
// Folds the symmetric taps with a pre-add, accumulates, scales and clamps.
module cic_comp_mac
    import cic_comp_pkg::*;
#(
    parameter int DW   = 35,
    parameter int CW   = 31,
    parameter int ACCW = 70
) (
    input  logic [7:0][DW-1:0] i_x,
    input  logic               i_odd,
    output logic [DW-1:0]      o_y,
    output logic               o_sat
);

    localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] MINV = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [DW:0]     w_pre  [4];
    logic signed [CW-1:0]   w_coef [4];
    logic signed [ACCW-1:0] w_acc;
    logic signed [ACCW-1:0] w_r;

    function automatic logic signed [DW:0] sx(input logic [DW-1:0] v);
        return $signed({v[DW-1], v});
    endfunction

    // Pair up mirror-image taps for the selected branch
    always_comb begin
        if (i_odd) begin
            w_pre[0]  = sx(i_x[0]) + sx(i_x[6]);
            w_pre[1]  = sx(i_x[1]) + sx(i_x[5]);
            w_pre[2]  = sx(i_x[2]) + sx(i_x[4]);
            w_pre[3]  = sx(i_x[3]);
            w_coef[0] = COMP_C1;
            w_coef[1] = COMP_C3;
            w_coef[2] = COMP_C5;
            w_coef[3] = COMP_C7;
        end else begin
            w_pre[0]  = sx(i_x[0]) + sx(i_x[7]);
            w_pre[1]  = sx(i_x[1]) + sx(i_x[6]);
            w_pre[2]  = sx(i_x[2]) + sx(i_x[5]);
            w_pre[3]  = sx(i_x[3]) + sx(i_x[4]);
            w_coef[0] = COMP_C0;
            w_coef[1] = COMP_C2;
            w_coef[2] = COMP_C4;
            w_coef[3] = COMP_C6;
        end
    end

    // Multiply-accumulate, floor-scale, clamp to the output range
    always_comb begin
        w_acc = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            w_acc = w_acc + ACCW'(w_pre[k]) * ACCW'(w_coef[k]);
        end
        w_r   = w_acc >>> SHIFT;
        o_y   = w_r[DW-1:0];
        o_sat = 1'b0;
        if (w_r > MAXV) begin
            o_y   = MAXV[DW-1:0];
            o_sat = 1'b1;
        end else if (w_r < MINV) begin
            o_y   = MINV[DW-1:0];
            o_sat = 1'b1;
        end
    end

endmodule

// File: rtl/cic_comp_interp.sv
// x2 CIC compensation interpolator: handshake, delay line, phase FSM,
// and two register stages behind the shared MAC.
module cic_comp_interp
    import cic_comp_pkg::*;
#(
    parameter int DW   = 35,
    parameter int CW   = 31,
    parameter int ACCW = 70
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_vld_in,
    output logic          in_rdy,
    input  logic [DW-1:0] dat_in,
    output logic          clk_vld_out,
    output logic [DW-1:0] dat_out,
    output logic          sat_pulse
);

    comp_state_e        r_state;
    comp_state_e        w_next;
    logic               w_accept;
    logic [7:0][DW-1:0] r_x;
    logic [DW-1:0]      w_mac_y;
    logic               w_mac_sat;
    logic               r_mac_vld;
    logic               r_mac_sat;
    logic [DW-1:0]      r_mac_y;

    // Next-state and ready decode
    always_comb begin
        w_next   = r_state;
        in_rdy   = (r_state == ST_IDLE) || (r_state == ST_PH1);
        w_accept = clk_vld_in && in_rdy;
        unique case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_PH0;
            ST_PH0:  w_next = ST_PH1;
            ST_PH1:  w_next = w_accept ? ST_PH0 : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Delay line shifts only on an accepted sample; x[0] is the newest
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_x <= '0;
        else if (w_accept) r_x <= {r_x[6:0], dat_in};
    end

    cic_comp_mac #(
        .DW   (DW),
        .CW   (CW),
        .ACCW (ACCW)
    ) u_mac (
        .i_x   (r_x),
        .i_odd (r_state == ST_PH1),
        .o_y   (w_mac_y),
        .o_sat (w_mac_sat)
    );

    // Capture the branch result at the end of its phase state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mac_vld <= 1'b0;
            r_mac_sat <= 1'b0;
            r_mac_y   <= '0;
        end else begin
            r_mac_vld <= (r_state == ST_PH0) || (r_state == ST_PH1);
            r_mac_sat <= w_mac_sat;
            r_mac_y   <= w_mac_y;
        end
    end

    // Output stage: pulse on each new sample, hold data in between
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_vld_out <= 1'b0;
            sat_pulse   <= 1'b0;
            dat_out     <= '0;
        end else begin
            clk_vld_out <= r_mac_vld;
            sat_pulse   <= r_mac_vld && r_mac_sat;
            if (r_mac_vld) dat_out <= r_mac_y;
        end
    end

endmodule

// File: tb/tb_cic_comp_interp.sv
// Self-checking bench for cic_comp_interp: an arithmetic reference model
// over the accepted-sample history plus directed literal checks.
module tb_cic_comp_interp;

    localparam int DW = 35;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clk_vld_in = 1'b0;
    logic          in_rdy;
    logic [DW-1:0] dat_in = '0;
    logic          clk_vld_out;
    logic [DW-1:0] dat_out;
    logic          sat_pulse;

    cic_comp_interp #(
        .DW   (35),
        .CW   (31),
        .ACCW (70)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_vld_in  (clk_vld_in),
        .in_rdy      (in_rdy),
        .dat_in      (dat_in),
        .clk_vld_out (clk_vld_out),
        .dat_out     (dat_out),
        .sat_pulse   (sat_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic longint sv(input logic [DW-1:0] v);
        return longint'($signed(v));
    endfunction

    // Full 15-tap response split into even/odd output phases
    longint HE [8] = '{-6421026, 34811522, -116533699, 356375486,
                       356375486, -116533699, 34811522, -6421026};
    longint HO [7] = '{-1088314, 8641811, -53216433, 628155438,
                       -53216433, 8641811, -1088314};

    longint hist [8];
    longint exp_q [$];
    bit     exps_q [$];
    longint got_q [$];
    bit     gsat_q [$];
    longint last_exp = 0;
    longint m_y;
    bit     m_s;
    longint e_y;
    bit     e_s;

    function automatic void model_out(input bit odd, output longint y, output bit s);
        logic signed [127:0] acc, a, b, r, mx, mn;
        acc = 0;
        mx  = (128'sd1 <<< 34) - 1;
        mn  = -(128'sd1 <<< 34);
        for (int j = 0; j < 8; j++) begin
            a = hist[j];
            if (odd) b = (j < 7) ? HO[j] : 0;
            else     b = HE[j];
            acc = acc + a * b;
        end
        r = acc >>> 29;
        s = 1'b0;
        if (r > mx) begin r = mx; s = 1'b1; end
        else if (r < mn) begin r = mn; s = 1'b1; end
        y = longint'(r);
    endfunction

    // Model update on accepts, and per-cycle output comparison
    always @(negedge clk) begin
        if (rst) begin
            for (int j = 0; j < 8; j++) hist[j] = 0;
            exp_q.delete();
            exps_q.delete();
        end else begin
            if (clk_vld_in && in_rdy) begin
                for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
                hist[0] = sv(dat_in);
                model_out(1'b0, m_y, m_s);
                exp_q.push_back(m_y);
                exps_q.push_back(m_s);
                model_out(1'b1, m_y, m_s);
                exp_q.push_back(m_y);
                exps_q.push_back(m_s);
            end
            if (clk_vld_out) begin
                got_q.push_back(sv(dat_out));
                gsat_q.push_back(sat_pulse);
                chk("pulse_has_expected", longint'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e_y = exp_q.pop_front();
                    e_s = exps_q.pop_front();
                    chk("model_dat_out", sv(dat_out), e_y);
                    chk("model_sat_pulse", longint'(sat_pulse), longint'(e_s));
                    last_exp = e_y;
                end
            end else begin
                chk("sat_without_vld", longint'(sat_pulse), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input longint v);
        bit took;
        int guard;
        clk_vld_in = 1'b1;
        dat_in     = DW'(v);
        took  = 1'b0;
        guard = 0;
        while (!took && guard < 20) begin
            took = in_rdy;
            tick();
            guard++;
        end
        chk("send_accepted", longint'(took), 1);
    endtask

    task automatic idle(input int n);
        clk_vld_in = 1'b0;
        repeat (n) tick();
    endtask

    function automatic void clear_got();
        got_q.delete();
        gsat_q.delete();
    endfunction

    longint M;
    int     cnt;
    bit     rdy_log [12];
    bit     vo_log  [12];
    longint sat_seq [8];

    initial begin
        M = (64'sd1 <<< 34) - 1;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_clk_vld_out", longint'(clk_vld_out), 0);
        chk("rst_dat_out", sv(dat_out), 0);
        chk("rst_sat_pulse", longint'(sat_pulse), 0);
        chk("rst_in_rdy", longint'(in_rdy), 1);
        rst = 1'b0;
        tick();

        // Impulse response pins c0..c3 scaling
        clear_got();
        send(64'sd1 <<< 20);
        send(0);
        idle(6);
        chk("imp_count", got_q.size(), 4);
        if (got_q.size() >= 4) begin
            chk("imp_y0", got_q[0], -12542);
            chk("imp_y1", got_q[1], -2126);
            chk("imp_y2", got_q[2], 67991);
            chk("imp_y3", got_q[3], 16878);
        end

        // DC gain
        clear_got();
        repeat (12) send(1000);
        idle(6);
        chk("dc_count", got_q.size(), 24);
        if (got_q.size() >= 24) begin
            chk("dc_even", got_q[22], 999);
            chk("dc_odd", got_q[23], 999);
            chk("dc_sat", longint'(gsat_q[23]), 0);
        end

        // Reset while in PH0 drops the in-flight pair and clears the line
        send(123456);
        clk_vld_in = 1'b0;
        rst = 1'b1;
        tick();
        chk("midrst_clk_vld_out", longint'(clk_vld_out), 0);
        chk("midrst_dat_out", sv(dat_out), 0);
        chk("midrst_in_rdy", longint'(in_rdy), 1);
        rst = 1'b0;
        tick();
        clear_got();
        send(0);
        idle(6);
        chk("midrst_count", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            chk("midrst_line_even", got_q[0], 0);
            chk("midrst_line_odd", got_q[1], 0);
        end

        // Sustained input: ready alternates, outputs every cycle after latency
        clk_vld_in = 1'b1;
        dat_in     = DW'(5);
        for (int k = 0; k < 12; k++) begin
            rdy_log[k] = in_rdy;
            vo_log[k]  = clk_vld_out;
            tick();
        end
        idle(6);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("thr_in_rdy[%0d]", k), longint'(rdy_log[k]), longint'(k % 2 == 0));
            chk($sformatf("thr_vld_out[%0d]", k), longint'(vo_log[k]), longint'(k >= 3));
        end

        // Single sample then a gap: exactly two pulses, output holds
        cnt = 0;
        send(7);
        clk_vld_in = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            cnt += int'(clk_vld_out);
        end
        chk("gap_pulses", cnt, 2);
        chk("gap_idle_rdy", longint'(in_rdy), 1);
        chk("gap_hold", sv(dat_out), last_exp);
        idle(3);
        chk("gap_hold_later", sv(dat_out), last_exp);

        // Saturation: tap signs match he, oldest sample first
        sat_seq = '{-M, M, -M, M, M, -M, M, -M};
        clear_got();
        for (int k = 0; k < 8; k++) send(sat_seq[k]);
        idle(6);
        chk("sat_count", got_q.size(), 16);
        if (got_q.size() >= 16) begin
            chk("sat_even_value", got_q[14], M);
            chk("sat_even_flag", longint'(gsat_q[14]), 1);
        end

        chk("no_lost_outputs", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
